// File: rtl/uart_rx_if.sv
// CPU-side bus of the UART receiver: command in, byte and status out.
// The master drives CONTROL; the receiver block is the slave.
interface uart_rx_if;
    logic [7:0] CONTROL;
    logic [7:0] DATA;
    logic [7:0] STATUS;

    modport master (
        output CONTROL,
        input  DATA,
        input  STATUS
    );

    modport slave (
        input  CONTROL,
        output DATA,
        output STATUS
    );
endinterface

// File: rtl/uart_rx_block.sv
// 8N1 UART receiver, LSB first, oversampled with glitch-rejecting start.
// Holds one byte for the CPU with VALID/FERR/OVERRUN/BUSY status.
module uart_rx_block #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     LINE_IN,
    uart_rx_if.slave bus
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [SW-1:0] SC_MAX  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;
    logic          tick;
    logic          ack;

    // Next-state logic: synchronizer, tick divider, receive FSM and status flags.
    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        sync1_d = LINE_IN;
        rx_s_d  = sync1_q;

        tick  = (div_q == DIV_MAX);
        div_d = tick ? '0 : div_q + DW'(1);

        // ACK clears the flags; a byte completing this cycle overrides below.
        ack = (bus.CONTROL == 8'hFF);
        if (ack) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    sc_d    = '0;
                    div_d   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sc_q == SC_MID) begin
                        sc_d    = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (sc_q == SC_MAX) begin
                        sc_d           = '0;
                        shreg_d[bit_q] = rx_s_q;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (sc_q == SC_MAX) begin
                        sc_d   = '0;
                        data_d = shreg_q;
                        if (rx_s_q) begin
                            valid_d = 1'b1;
                            ovr_d   = ack ? 1'b0 : (ovr_q | valid_q);
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset; line idles high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            div_q   <= '0;
            sc_q    <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            div_q   <= div_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.DATA   = data_q;
    assign bus.STATUS = {4'b0000, busy_q, ovr_q, ferr_q, valid_q};

endmodule

// File: tb/tb_uart_rx_block.sv
// Bench for uart_rx_block: directed frames, expected events queued
// and checked by a monitor on every BUSY falling edge.
module tb_uart_rx_block;

    logic clk;
    logic rst;
    logic line;
    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   mon_en;
    bit   busy_prev;

    typedef struct {
        logic [7:0] d;
        logic [7:0] s;
        bit         lat;
        int         c0;
    } exp_t;

    exp_t q[$];

    uart_rx_if bus ();

    uart_rx_block #(
        .CLK_HZ    (614400),
        .BAUD      (9600),
        .OVERSAMPLE(16)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .LINE_IN(line),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] s,
                        input bit lat);
        exp_t e;
        e.d   = d;
        e.s   = s;
        e.lat = lat;
        e.c0  = cyc;
        q.push_back(e);
    endtask

    // Behavioural transmitter: start, 8 data bits LSB first, stop, short idle.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int stop_len);
        line = 1'b0;
        tick(64);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            tick(64);
        end
        line = stop;
        tick(stop_len);
        line = 1'b1;
        tick(16);
    endtask

    task automatic ack_pulse;
        bus.CONTROL = 8'hFF;
        tick(1);
        bus.CONTROL = 8'h00;
    endtask

    // Monitor: every end of activity (BUSY falling) consumes one expected event.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (mon_en && busy_prev && !bus.STATUS[3]) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: DATA=%h STATUS=%h, required no event",
                             bus.DATA, bus.STATUS);
                end else begin
                    e = q.pop_front();
                    check("sb_data", {24'd0, bus.DATA}, {24'd0, e.d});
                    check("sb_status", {24'd0, bus.STATUS}, {24'd0, e.s});
                    if (e.lat) begin
                        lat = cyc - e.c0;
                        n_chk++;
                        if (lat < 606 || lat > 614) begin
                            n_fail++;
                            $display("FAIL sb_latency: actual %0d CLK required 606..614",
                                     lat);
                        end
                    end
                end
            end
            busy_prev = bus.STATUS[3];
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual no finish required finish by 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        mon_en      = 1'b0;
        busy_prev   = 1'b0;
        rst         = 1'b1;
        line        = 1'b1;
        bus.CONTROL = 8'h00;
        tick(4);
        check("rst_data", {24'd0, bus.DATA}, 32'h00);
        check("rst_status", {24'd0, bus.STATUS}, 32'h00);
        rst = 1'b0;
        tick(4);
        mon_en = 1'b1;

        // Good frame
        push(8'hA5, 8'h01, 1'b1);
        send_frame(8'hA5, 1'b1, 64);
        tick(20);

        // Glitched start bit
        ack_pulse();
        push(8'hA5, 8'h00, 1'b0);
        line = 1'b0;
        tick(20);
        line = 1'b1;
        tick(100);

        // Stop bit held low: framing error and break
        push(8'h3C, 8'h02, 1'b0);
        fork
            send_frame(8'h3C, 1'b0, 200);
            begin
                tick(700);
                check("brk_status", {24'd0, bus.STATUS}, 32'h0A);
            end
        join
        tick(20);
        check("ferr_status", {24'd0, bus.STATUS}, 32'h02);
        check("ferr_data", {24'd0, bus.DATA}, 32'h3C);
        ack_pulse();
        tick(100);
        check("ferr_once", {24'd0, bus.STATUS}, 32'h00);

        // Two frames without ACK: overrun
        push(8'h11, 8'h01, 1'b1);
        send_frame(8'h11, 1'b1, 64);
        push(8'h22, 8'h05, 1'b1);
        send_frame(8'h22, 1'b1, 64);
        tick(10);
        ack_pulse();
        check("ovr_ack_status", {24'd0, bus.STATUS}, 32'h00);
        check("ovr_ack_data", {24'd0, bus.DATA}, 32'h22);

        // ACK held across byte completion
        push(8'h7E, 8'h01, 1'b1);
        fork
            send_frame(8'h7E, 1'b1, 64);
            begin
                tick(600);
                bus.CONTROL = 8'hFF;
                tick(20);
                bus.CONTROL = 8'h00;
            end
        join
        tick(4);
        check("ackhold_status", {24'd0, bus.STATUS}, 32'h00);
        check("ackhold_data", {24'd0, bus.DATA}, 32'h7E);

        // Reset in the middle of bit 4 of a frame
        line = 1'b0;
        tick(64);
        for (int i = 0; i < 4; i++) begin
            line = (i % 2 == 1);
            tick(64);
        end
        line = 1'b0;
        tick(32);
        push(8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        tick(1);
        rst  = 1'b0;
        line = 1'b1;
        check("midrst_status", {24'd0, bus.STATUS}, 32'h00);
        check("midrst_data", {24'd0, bus.DATA}, 32'h00);
        tick(200);
        push(8'hC3, 8'h01, 1'b1);
        send_frame(8'hC3, 1'b1, 64);

        // Loopback byte stream
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            b = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h55;
            ack_pulse();
            push(b, 8'h01, 1'b1);
            send_frame(b, 1'b1, 64);
        end

        tick(50);
        check("sb_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
